multicycle_alu_md: RTL and testbench
====================================

Name: multicycle_alu_md

Overview:
- Parametrised next-generation ALU for the multicycle datapath, with operand muxing from A/B/PC/immediate.
- Single-cycle logic/arith/shift/compare ops feed a registered aluout, as before.
- Adds an iterative multiply/divide unit with a start/busy/done handshake and HI/LO result registers, for MIPS mult/div.

Parameters:
- WIDTH, 32, datapath width; must be even and at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- data1  in  WIDTH  register A operand
- data2  in  WIDTH  register B operand
- pcvalue  in  WIDTH  PC operand
- signextend_result  in  WIDTH  sign-extended immediate
- signextend_result_shift  in  WIDTH  sign-extended immediate shifted left by 2
- AluSrcA  in  1  source A select: 1 = data1, 0 = pcvalue
- AluSrcB  in  2  source B select: 00 = data2, 01 = constant 1, 10 = signextend_result, 11 = signextend_result_shift
- controlline  in  4  operation code
- start  in  1  launches MULTU/DIVU when controlline holds a long-op code
- aluresult  out  WIDTH  combinational result
- aluout  out  WIDTH  registered result
- zero  out  1  combinational flag, src1 == src2
- busy  out  1  multiply/divide in progress
- done  out  1  one-cycle pulse when HI/LO are updated
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Operand muxes are combinational, exactly as the select encodings above; the constant 1 is zero-extended to WIDTH.
- Single-cycle opcodes, with src1 = s1 and src2 = s2:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR.
  - 0110 SUB.
  - 0111 SLT (signed), 1100 SLTU (unsigned); both give 1 or 0, zero-extended.
  - 0101 SLL: s2 << s1[SHW-1:0].
  - 1000 SRL: s2 >> s1[SHW-1:0].
  - 1001 SRA: arithmetic right shift of s2 by s1[SHW-1:0].
  - ADD and SUB are modulo 2^WIDTH; there is no overflow flag.
  - Every other code gives aluresult = 0.
- Long-op codes: 1010 MULTU, 1011 DIVU. These drive aluresult = 0.
- zero = (s1 == s2), independent of controlline.
- aluout <= aluresult on every rising edge, including while busy. Reset value is 0.
- Long-op launch:
  - Launches when start = 1, busy = 0 and controlline ∈ {1010, 1011}.
  - At that edge the unit latches s1 and s2 as multiplicand/dividend and multiplier/divisor, sets busy = 1 and loads counter = WIDTH.
- Long-op iteration:
  - One radix-2 step per cycle: shift-add for MULTU, restoring shift-subtract for DIVU.
  - On the edge where counter goes 1 -> 0: hi/lo take their final values, busy drops to 0, and done = 1 for exactly that one cycle.
  - done therefore rises WIDTH edges after the launch edge.
- Results:
  - MULTU: {hi, lo} = s1 * s2, a 2*WIDTH-bit unsigned product.
  - DIVU: lo = s1 / s2, hi = s1 % s2, both unsigned.
- Divide by zero still takes the full WIDTH cycles, then gives lo = all ones and hi = dividend.
- hi and lo are never written except at done, so they hold their old values while busy.
- start while busy = 1 is ignored; the current operation is not disturbed.
- start with a non-long opcode is ignored.
- Simultaneous done and start in the same cycle: busy is still 1 on that edge, so the start is ignored. The controller must re-issue start.
- Reset (asynchronous, at any time including mid-operation):
  - busy = 0, done = 0, counter = 0, hi = 0, lo = 0, aluout = 0.
  - Any in-flight operation is abandoned with no partial write.
- No X propagation: all internal working registers reset to 0.

Decomposition:
- Package multicycle_alu_pkg holds:
  - 4-bit opcode localparams: OP_AND, OP_OR, OP_ADD, OP_XOR, OP_NOR, OP_SLL, OP_SUB, OP_SLT, OP_SRL, OP_SRA, OP_MULTU, OP_DIVU, OP_SLTU.
  - ALUSRCB_* select constants.
- One sub-module, muldiv_iter:
  - Parameter WIDTH.
  - Ports clk, rst_n, start, is_div, a, b, busy, done, hi, lo.
  - Holds the counter, the working registers and the handshake.
- The top level contains the operand muxes, the single-cycle ALU case statement, the zero flag and the aluout register.

Test Plan:
- ALU ops, WIDTH=32, AluSrcA=1, AluSrcB=00:
  - data1=7, data2=9: ADD -> aluresult=16, aluout=16 one edge later.
  - data1=7, data2=9: SUB -> 0xFFFFFFFE.
  - data1=0xFFFFFFFF, data2=1: SLT -> 1; SLTU -> 0.
  - data1=4, data2=0x80000000: SRA -> 0xF8000000; SRL -> 0x08000000.
- Muxes: AluSrcA=0, pcvalue=0x100, AluSrcB=01, ADD -> 0x101. AluSrcB=11 with signextend_result_shift=0x10 -> 0x110. zero=1 when data1=data2=5 with AluSrcA=1, AluSrcB=00.
- MULTU: s1=0xFFFFFFFF, s2=0xFFFFFFFF, start pulse -> busy for 32 cycles; done on edge 32; hi=0xFFFFFFFE, lo=0x00000001; done high exactly 1 cycle.
- DIVU: 100 / 7 -> lo=14, hi=2 at edge 32. Divide by zero, 100 / 0 -> lo=0xFFFFFFFF, hi=100.
- Handshake: start re-pulsed at edges 5 and 32 of a running MULTU -> ignored, result unchanged. Reset asserted at edge 10 of DIVU -> busy=0, hi=lo=0 immediately, no done afterwards.
- Parametric: WIDTH=16 MULTU 0xFFFF*0x0002 -> hi=0x0001, lo=0xFFFE, done at edge 16; SLL by 17 uses s1[3:0]=1.

Source files
------------

// File: rtl/multicycle_alu_pkg.sv
// Shared opcode and operand-select encodings for the multicycle ALU.
package multicycle_alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_SLTU  = 4'b1100;

  localparam logic [1:0] ALUSRCB_DATA2  = 2'b00;
  localparam logic [1:0] ALUSRCB_ONE    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/multicycle_alu_md_muldiv_iter.sv
// Radix-2 iterative unsigned multiply (shift-add) / divide (restoring), one step per cycle.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, is_div_q, is_div_d;
  logic [WIDTH-1:0] wh_q, wh_d, wl_q, wl_d, op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] step_hi, step_lo;

  // wh/wl hold {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, wh_q} + (wl_q[0] ? {1'b0, op_q} : '0);
    div_sh  = {wh_q, wl_q[WIDTH-1]};
    if (is_div_q) begin
      // Explicit compare keeps divide-by-zero correct: every step subtracts 0.
      if (div_sh >= {1'b0, op_q}) begin
        step_hi = WIDTH'(div_sh - {1'b0, op_q});
        step_lo = {wl_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_sh[WIDTH-1:0];
        step_lo = {wl_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], wl_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    is_div_d = is_div_q;
    wh_d     = wh_q;
    wl_d     = wl_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (busy_q) begin
      wh_d  = step_hi;
      wl_d  = step_lo;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        hi_d   = step_hi;
        lo_d   = step_lo;
      end
    end else if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CW'(WIDTH);
      is_div_d = is_div;
      wh_d     = '0;
      wl_d     = a;
      op_d     = b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      wh_q     <= '0;
      wl_q     <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      is_div_q <= is_div_d;
      wh_q     <= wh_d;
      wl_q     <= wl_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/multicycle_alu_md.sv
// Multicycle-datapath ALU: operand muxes, single-cycle ops, registered aluout, iterative mul/div.
module multicycle_alu_md
  import multicycle_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] pcvalue,
  input  logic [WIDTH-1:0] signextend_result,
  input  logic [WIDTH-1:0] signextend_result_shift,
  input  logic             AluSrcA,
  input  logic [1:0]       AluSrcB,
  input  logic [3:0]       controlline,
  input  logic             start,
  output logic [WIDTH-1:0] aluresult,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] s1, s2, aluout_q;
  logic [SHW-1:0]   shamt;
  logic             long_start, is_div;

  always_comb begin
    s1 = AluSrcA ? data1 : pcvalue;
    unique case (AluSrcB)
      ALUSRCB_DATA2: s2 = data2;
      ALUSRCB_ONE:   s2 = One;
      ALUSRCB_IMM:   s2 = signextend_result;
      default:       s2 = signextend_result_shift;
    endcase
  end

  assign shamt = s1[SHW-1:0];
  assign zero  = (s1 == s2);

  always_comb begin
    aluresult = '0;
    case (controlline)
      OP_AND:  aluresult = s1 & s2;
      OP_OR:   aluresult = s1 | s2;
      OP_ADD:  aluresult = s1 + s2;
      OP_XOR:  aluresult = s1 ^ s2;
      OP_NOR:  aluresult = ~(s1 | s2);
      OP_SUB:  aluresult = s1 - s2;
      OP_SLT:  aluresult = ($signed(s1) < $signed(s2)) ? One : '0;
      OP_SLTU: aluresult = (s1 < s2) ? One : '0;
      OP_SLL:  aluresult = s2 << shamt;
      OP_SRL:  aluresult = s2 >> shamt;
      OP_SRA:  aluresult = $signed(s2) >>> shamt;
      default: aluresult = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluout_q <= '0;
    end else begin
      aluout_q <= aluresult;
    end
  end

  assign aluout = aluout_q;

  // The iterator itself ignores start while busy.
  assign is_div     = (controlline == OP_DIVU);
  assign long_start = start && ((controlline == OP_MULTU) || is_div);

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (long_start),
    .is_div(is_div),
    .a     (s1),
    .b     (s2),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_multicycle_alu_md.sv
// Self-checking bench: vector table for single-cycle ops, scoreboarded long ops, WIDTH=16 instance.
module tb_multicycle_alu_md;
  import multicycle_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data1, data2, pcvalue, se, se_sh;
  logic        srca, start;
  logic [1:0]  srcb;
  logic [3:0]  op;
  logic [31:0] aluresult, aluout, hi, lo;
  logic        zero, busy, done;

  logic [15:0] d1_16, d2_16, res16, out16, hi16, lo16;
  logic [3:0]  op16;
  logic        start16, zero16, busy16, done16;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] alu_q[$];
  logic [63:0] long_q[$];
  logic [63:0] last_hl;

  always #5 clk = ~clk;

  multicycle_alu_md #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .data1(data1), .data2(data2), .pcvalue(pcvalue),
    .signextend_result(se), .signextend_result_shift(se_sh), .AluSrcA(srca),
    .AluSrcB(srcb), .controlline(op), .start(start), .aluresult(aluresult),
    .aluout(aluout), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  multicycle_alu_md #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .data1(d1_16), .data2(d2_16), .pcvalue(16'h0),
    .signextend_result(16'h0), .signextend_result_shift(16'h0), .AluSrcA(1'b1),
    .AluSrcB(2'b00), .controlline(op16), .start(start16), .aluresult(res16),
    .aluout(out16), .zero(zero16), .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
  );

  typedef struct {
    logic [31:0] a, b, pc, imm, imm_sh;
    logic        sa;
    logic [1:0]  sb;
    logic [3:0]  op;
    logic [31:0] exp;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic [31:0] a, b, pc, imm, imm_sh, input logic sa,
                              input logic [1:0] sb, input logic [3:0] o,
                              input logic [31:0] e, input logic ez);
    vec_t v;
    v.a = a; v.b = b; v.pc = pc; v.imm = imm; v.imm_sh = imm_sh;
    v.sa = sa; v.sb = sb; v.op = o; v.exp = e; v.exp_zero = ez;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input int i);
    logic [31:0] e;
    @(negedge clk);
    data1 = vecs[i].a; data2 = vecs[i].b; pcvalue = vecs[i].pc;
    se = vecs[i].imm; se_sh = vecs[i].imm_sh; srca = vecs[i].sa; srcb = vecs[i].sb;
    op = vecs[i].op; start = 1'b0;
    alu_q.push_back(vecs[i].exp);
    #1;
    chk($sformatf("vec%0d aluresult", i), 64'(aluresult), 64'(vecs[i].exp));
    chk($sformatf("vec%0d zero", i), 64'(zero), 64'(vecs[i].exp_zero));
    @(posedge clk); #1;
    e = alu_q.pop_front();
    chk($sformatf("vec%0d aluout", i), 64'(aluout), 64'(e));
  endtask

  // rst_at > 0 asserts reset just after that edge; repulse re-raises start at edges 5 and 32.
  task automatic run_long(input logic [31:0] a, b, input logic div, input bit repulse,
                          input int rst_at);
    logic [63:0] exp, got_e;
    int          done_edge, pulses;
    bit          aborted;
    if (div) exp = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    else     exp = {32'h0, a} * {32'h0, b};
    @(negedge clk);
    data1 = a; data2 = b; srca = 1'b1; srcb = ALUSRCB_DATA2;
    op = div ? OP_DIVU : OP_MULTU; start = 1'b1;
    long_q.push_back(exp);
    @(posedge clk);
    done_edge = 0;
    aborted   = 1'b0;
    for (int k = 1; k <= 40 && done_edge == 0 && !aborted; k++) begin
      @(negedge clk);
      start = repulse && (k == 5 || k == 32);
      if (start) begin data1 = 32'h3; data2 = 32'h5; end
      if (k == 1) begin
        chk("long busy after launch", 64'(busy), 64'(1));
        chk("long hi/lo held while busy", {hi, lo}, last_hl);
      end
      @(posedge clk); #1;
      if (rst_at == k) begin
        rst_n = 1'b0;
        #1;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset hi/lo", {hi, lo}, 64'(0));
        chk("reset done", 64'(done), 64'(0));
        long_q.delete();
        last_hl = '0;
        #2 rst_n = 1'b1;
        aborted = 1'b1;
      end else if (done) begin
        done_edge = k;
      end
    end
    start = 1'b0;
    if (aborted) begin
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (done || busy) pulses++;
      end
      chk("no activity after reset", 64'(pulses), 64'(0));
    end else begin
      chk("done edge", 64'(done_edge), 64'(32));
      chk("busy low at done", 64'(busy), 64'(0));
      if (long_q.size() == 0) begin
        chk("scoreboard empty at done", 64'(1), 64'(0));
      end else begin
        got_e = long_q.pop_front();
        chk(div ? "divu hi/lo" : "multu hi/lo", {hi, lo}, got_e);
        last_hl = got_e;
      end
      @(negedge clk);
      @(posedge clk); #1;
      chk("done one cycle", 64'(done), 64'(0));
      chk("no relaunch", 64'(busy), 64'(0));
    end
  endtask

  initial begin
    logic [31:0] p16;
    int          de16;
    vecs[0]  = mk(32'd7, 32'd9, 0, 0, 0, 1'b1, 2'b00, OP_ADD, 32'd16, 1'b0);
    vecs[1]  = mk(32'd7, 32'd9, 0, 0, 0, 1'b1, 2'b00, OP_SUB, 32'hFFFF_FFFE, 1'b0);
    vecs[2]  = mk(32'hFFFF_FFFF, 32'd1, 0, 0, 0, 1'b1, 2'b00, OP_SLT, 32'd1, 1'b0);
    vecs[3]  = mk(32'hFFFF_FFFF, 32'd1, 0, 0, 0, 1'b1, 2'b00, OP_SLTU, 32'd0, 1'b0);
    vecs[4]  = mk(32'd4, 32'h8000_0000, 0, 0, 0, 1'b1, 2'b00, OP_SRA, 32'hF800_0000, 1'b0);
    vecs[5]  = mk(32'd4, 32'h8000_0000, 0, 0, 0, 1'b1, 2'b00, OP_SRL, 32'h0800_0000, 1'b0);
    vecs[6]  = mk(32'd0, 32'd0, 32'h100, 0, 0, 1'b0, 2'b01, OP_ADD, 32'h101, 1'b0);
    vecs[7]  = mk(32'd0, 32'd0, 32'h100, 0, 32'h10, 1'b0, 2'b11, OP_ADD, 32'h110, 1'b0);
    vecs[8]  = mk(32'd5, 32'd5, 0, 0, 0, 1'b1, 2'b00, OP_AND, 32'd5, 1'b1);
    vecs[9]  = mk(32'hF0F0, 32'h0FF0, 0, 0, 0, 1'b1, 2'b00, OP_OR, 32'hFFF0, 1'b0);
    vecs[10] = mk(32'hF0F0, 32'h0FF0, 0, 0, 0, 1'b1, 2'b00, OP_XOR, 32'hFF00, 1'b0);
    vecs[11] = mk(32'hF0F0, 32'h0FF0, 0, 0, 0, 1'b1, 2'b00, OP_NOR, 32'hFFFF_000F, 1'b0);
    vecs[12] = mk(32'd3, 32'd1, 0, 0, 0, 1'b1, 2'b00, OP_SLL, 32'd8, 1'b0);
    vecs[13] = mk(32'h20, 32'd0, 0, 32'hFFFF_FFF0, 0, 1'b1, 2'b10, OP_ADD, 32'h10, 1'b0);
    vecs[14] = mk(32'd5, 32'd5, 0, 0, 0, 1'b1, 2'b00, 4'b1101, 32'd0, 1'b1);
    vecs[15] = mk(32'd7, 32'd9, 0, 0, 0, 1'b1, 2'b00, OP_MULTU, 32'd0, 1'b0);
    vecs[16] = mk(32'h21, 32'd1, 0, 0, 0, 1'b1, 2'b00, OP_SLL, 32'd2, 1'b0);

    rst_n = 1'b0; start = 1'b0; data1 = '0; data2 = '0; pcvalue = '0; se = '0; se_sh = '0;
    srca = 1'b1; srcb = 2'b00; op = OP_AND;
    d1_16 = '0; d2_16 = '0; op16 = OP_AND; start16 = 1'b0;
    last_hl = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset aluout", 64'(aluout), 64'(0));
    chk("reset busy/done", {busy, done}, 64'(0));
    chk("reset hi/lo", {hi, lo}, 64'(0));
    chk("reset w16 hi/lo", {hi16, lo16}, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) apply_vec(i);

    run_long(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    run_long(32'd100, 32'd7, 1'b1, 1'b0, 0);
    run_long(32'd100, 32'd0, 1'b1, 1'b0, 0);
    run_long(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 0);
    run_long(32'hDEAD_BEEF, 32'h1234, 1'b1, 1'b0, 10);
    run_long(32'hDEAD_BEEF, 32'h1234, 1'b1, 1'b0, 0);

    // WIDTH=16: shift amount uses only s1[3:0], then a 16-cycle multiply.
    @(negedge clk);
    d1_16 = 16'd17; d2_16 = 16'd1; op16 = OP_SLL;
    #1;
    chk("w16 sll by 17", 64'(res16), 64'(2));
    @(negedge clk);
    d1_16 = 16'hFFFF; d2_16 = 16'h0002; op16 = OP_MULTU; start16 = 1'b1;
    p16 = {16'h0, d1_16} * {16'h0, d2_16};
    @(posedge clk);
    de16 = 0;
    for (int k = 1; k <= 24 && de16 == 0; k++) begin
      @(negedge clk);
      start16 = 1'b0;
      @(posedge clk); #1;
      if (done16) de16 = k;
    end
    chk("w16 done edge", 64'(de16), 64'(16));
    chk("w16 multu hi/lo", {hi16, lo16}, 64'(p16));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
